// File: rtl/tdc_pkg.sv
// tdc_pkg: shared receiver state type, 8N1 frame constants and baud divider helper
package tdc_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer (clk, rst, signal_in -> signal_out) with configurable reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  output logic signal_out
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {signal_out, meta} <= {2{RST_VAL}};
    else {signal_out, meta} <= {meta, signal_in};
endmodule

// File: rtl/tdc_uart_rx.sv
// tdc_uart_rx: 8N1 UART receiver (uart_rx in; rx_data/rx_valid with rx_ready handshake; frame_err/overrun pulses)
module tdc_uart_rx
  import tdc_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_100m,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  rx_state_t state;
  logic rx_s;
  logic [TW-1:0] timer;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic tick, idle_like, stop_ok, stop_bad;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk       (clk_100m),
    .rst       (rst),
    .signal_in (uart_rx),
    .signal_out(rx_s)
  );
  always_comb begin
    tick = timer == (state == START ? HALF_END : BIT_END);
    idle_like = state == IDLE || state == WAIT_IDLE;
    stop_ok = state == STOP && tick && rx_s;
    stop_bad = state == STOP && tick && !rx_s;
  end
  always_ff @(posedge clk_100m)
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      timer <= (tick || idle_like) ? '0 : timer + 1'b1;
      frame_err <= stop_bad;
      overrun <= stop_ok && rx_valid && !rx_ready;
      if (stop_ok && (!rx_valid || rx_ready)) begin
        rx_data <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        IDLE: if (!rx_s) state <= START;
        START:
          if (tick) begin
            state <= rx_s ? IDLE : DATA;
            bit_cnt <= '0;
          end
        DATA:
          if (tick) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end
        STOP: if (tick) state <= rx_s ? IDLE : WAIT_IDLE;
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/tdc_uart_rx.md
TDC_UART_RX -- requirements
Module: tdc_uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have port clk_100m, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port uart_rx, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data, output, 8, the received byte.
REQ-007 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready, input, 1, consumer accepts the byte.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse when a completed byte is dropped.

Function
REQ-011 SHALL compute CLKS_PER_BIT = CLK_FREQ/BAUD (integer, truncated; 868 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (434).
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer; all decoding uses the synchronized signal (rx_s).
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: on rx_s == 0, SHALL go to START and clear the bit-timer.
REQ-015 START: after HALF_BIT cycles, SHALL resample rx_s; 0 -> DATA with timer cleared; 1 -> IDLE (false start, no outputs).
REQ-016 DATA: every CLKS_PER_BIT cycles, SHALL shift rx_s into the shift register, LSB first; after the 8th bit, SHALL go to STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, SHALL sample rx_s; 1 -> deliver byte and go to IDLE; 0 -> pulse frame_err, discard byte, go to WAIT_IDLE.
REQ-018 WAIT_IDLE: SHALL remain until rx_s == 1, then go to IDLE (a break does not retrigger).
REQ-019 Delivery: rx_data/rx_valid SHALL update on the cycle after the stop sample.
REQ-020 Handshake: a transfer occurs when rx_valid && rx_ready; rx_valid SHALL drop the following cycle unless a new byte is delivered in that same cycle.
REQ-021 While rx_valid && !rx_ready, rx_data SHALL be stable.
REQ-022 If a byte completes while rx_valid is high and rx_ready is low, the held byte SHALL be kept, the new byte dropped, and overrun pulsed for one cycle.
REQ-023 If a byte completes in the same cycle rx_valid && rx_ready, the new byte SHALL be loaded, rx_valid SHALL stay high, and there SHALL be no overrun.
REQ-024 The bit timer SHALL be wide enough for CLKS_PER_BIT-1 ($clog2) and SHALL not wrap within a bit.
REQ-025 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-026 On rst, SHALL clear: state = IDLE, timer = 0, bit count = 0, rx_data = 8'h00, rx_valid = 0, frame_err = 0, overrun = 0, synchronizer flops = 1 (idle).
REQ-027 Reset mid-frame SHALL abort the frame with no delivery and no error pulse; reception SHALL resume on the next falling edge after rst is released.

Structure
REQ-028 A shared package tdc_pkg SHALL hold the state enum type, the UART frame constants (DATA_BITS = 8, STOP_BITS = 1) and a function computing clocks-per-bit from CLK_FREQ/BAUD.
REQ-029 The synchronizer SHALL be the sub-module sync_2ff (parameterized reset value), reusable for signal_in.

Verification
REQ-030 Send 0x55 at 115200, rx_ready = 1 -> rx_valid one cycle, rx_data = 0x55, about 9.5*868 + 2 cycles after the start edge; no error pulses.
REQ-031 Drive a 200-cycle low glitch on the idle line -> no rx_valid and no frame_err; state back in IDLE; then send 0xA3 -> rx_data = 0xA3.
REQ-032 Send 0xA3 with the stop bit forced low, then hold the line low 2000 cycles -> one frame_err pulse, no rx_valid; line high then 0x3C -> rx_data = 0x3C.
REQ-033 Send 0x11 then 0x22 back-to-back with rx_ready = 0 -> rx_data = 0x11 held, one overrun pulse; raise rx_ready -> 0x11 consumed, rx_valid low.
REQ-034 Send 0x12, 0x34 back-to-back with rx_ready = 1, timed so the second completes during the first's handshake cycle -> both received in order, no overrun.
REQ-035 Assert rst for 1 cycle during bit 4 of 0xFF -> no delivery; the next frame 0x81 is received correctly.
